alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
//  Upstream stage of the alu datapath. Buffers tagged operation commands (a, b, op)
//  arriving on a valid/ready port and issues them to the free-running, fixed-latency
//  alu one per cycle. Captures each alu result ALU_LATENCY cycles after issue and
//  returns it, with its tag, on a valid/ready response port.
//  Full back-pressure on both sides; strict in-order completion.
// PARAMETERS
//  WIDTH        8   operand width of a_in/b_in
//  OP_WIDTH     4   opcode width of op_in
//  RES_WIDTH    16  alu result_out width
//  TAG_WIDTH    4   command tag width
//  CMD_DEPTH    8   command FIFO entries (power of 2, >=2)
//  RSP_DEPTH    4   response FIFO entries (power of 2, >=2)
//  ALU_LATENCY  1   cycles from alu operands registered to result_out valid (>=1)
// PORTS
//  clock           in   1          system clock, rising edge
//  reset           in   1          asynchronous reset, active-high
//  cmd_valid_in    in   1          command present
//  cmd_ready_out   out  1          command FIFO can accept
//  cmd_a_in        in   WIDTH      operand a
//  cmd_b_in        in   WIDTH      operand b
//  cmd_op_in       in   OP_WIDTH   opcode
//  cmd_tag_in      in   TAG_WIDTH  command tag
//  alu_a_out       out  WIDTH      to alu a_in (registered)
//  alu_b_out       out  WIDTH      to alu b_in (registered)
//  alu_op_out      out  OP_WIDTH   to alu op_in (registered)
//  alu_result_in   in   RES_WIDTH  from alu result_out
//  rsp_valid_out   out  1          response present
//  rsp_ready_in    in   1          downstream accepts response
//  rsp_result_out  out  RES_WIDTH  captured alu result
//  rsp_tag_out     out  TAG_WIDTH  tag of that command
//  inflight_out    out  3          commands issued but not yet captured (saturating)
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO pointers/counts=0; in-flight pipe cleared.
//   Results in flight are discarded. All outputs=0, except cmd_ready_out=1.
//  Command accept: push when cmd_valid_in && cmd_ready_out.
//   cmd_ready_out = (cmd_count != CMD_DEPTH), from the registered count only.
//   A pop in the same cycle does not make a full FIFO ready.
//  Credit: credit = RSP_DEPTH - rsp_count - inflight.
//  Issue: when the cmd FIFO is non-empty and credit>0, pop the head and register it onto alu_*_out.
//   Insert {1,tag} into a valid/tag shift register of length ALU_LATENCY.
//   When not issuing, alu_*_out hold their last value and a 0 valid bit is shifted in.
//  Capture: when the pipe tail valid bit is 1, push {alu_result_in, tag} into the rsp FIFO.
//   The credit rule guarantees the rsp FIFO is never full at capture; assert this.
//  Response: rsp_valid_out = rsp FIFO non-empty; head drives rsp_result_out/rsp_tag_out.
//   Pop on rsp_valid_out && rsp_ready_in. Push and pop in the same cycle keep the count.
//   Pushing into an empty FIFO is visible the next cycle (no fall-through).
//  Latency (idle, rsp_ready_in=1): cmd accepted at edge N, issued N+1, captured N+1+ALU_LATENCY,
//   rsp_valid_out high after that edge.
//  Throughput: one command per cycle sustained while rsp_ready_in=1.
//  Ordering: responses leave in command-accept order; tags are opaque and never checked.
//  Pointers wrap modulo depth; counts are $clog2(DEPTH)+1 bits wide.
// STRUCTURE
//  alu_pkg: WIDTH/OP_WIDTH/RES_WIDTH/TAG_WIDTH constants.
//   Also the packed cmd_t {a,b,op,tag} and rsp_t {result,tag} typedefs, and the opcode enum.
//  Sub-module alu_sync_fifo #(type T, DEPTH): push/pop/full/empty/count, registered output.
//   Instantiated twice: command FIFO and response FIFO.
//  Top: issue/credit logic, alu operand registers, valid/tag shift pipe.
// TESTING
//  1 Single cmd a=8'h05 b=8'h03 op=ADD tag=2 -> one rsp, result=16'h0008, tag=2.
//    rsp_valid_out rises ALU_LATENCY+2 edges after accept.
//  2 Burst of 8 cmds, rsp_ready_in=1 -> cmd_ready_out stays high.
//    8 rsps on 8 consecutive cycles, tags 0..7 in order.
//  3 rsp_ready_in=0, push 16 cmds -> exactly RSP_DEPTH=4 issued.
//    CMD_DEPTH=8 buffered, cmd_ready_out=0; remaining 4 stalled.
//    Release ready: all 12 accepted cmds complete in order with correct results.
//  4 Full cmd FIFO with simultaneous pop -> cmd_ready_out still 0 that cycle.
//    No accept; ready=1 the next cycle.
//  5 Assert reset with 3 in flight and 2 queued.
//    Immediately rsp_valid_out=0, alu_*_out=0, cmd_ready_out=1, inflight_out=0.
//    No stale response after release.
//  6 Random 500 cmds with random rsp_ready_in, scoreboard vs alu reference model.
//    Zero mismatches, no rsp overflow assertion.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, command/response record types and opcode set for the alu datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ALU_* width constants, alu_op_e opcode enum, alu_cmd_t {a,b,op,tag},
//           alu_rsp_t {result,tag}.
package alu_pkg;

  localparam int ALU_WIDTH     = 8;
  localparam int ALU_OP_WIDTH  = 4;
  localparam int ALU_RES_WIDTH = 16;
  localparam int ALU_TAG_WIDTH = 4;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_MUL   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_PASSA = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0]     a;
    logic [ALU_WIDTH-1:0]     b;
    logic [ALU_OP_WIDTH-1:0]  op;
    logic [ALU_TAG_WIDTH-1:0] tag;
  } alu_cmd_t;

  typedef struct packed {
    logic [ALU_RES_WIDTH-1:0] result;
    logic [ALU_TAG_WIDTH-1:0] tag;
  } alu_rsp_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO of T records with registered storage and an occupancy count.
// Latency: a push into an empty FIFO shows on head_o after the next edge (no fall-through).
// Backpressure: push ignored while full, pop ignored while empty; full/empty/count from registers only.
// Ports: clock/reset (async, active-high); push_i/push_dat_i write side; pop_i read side;
//        head_o oldest entry (0 when empty); full_o, empty_o, count_o ($clog2(DEPTH)+1 bits).
module alu_sync_fifo
  import alu_pkg::*;
#(
  parameter type T     = alu_rsp_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  T                       push_dat_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; head is forced to zero while empty so stale
  // entries never leak out after reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers tagged alu commands, issues one per cycle to a fixed-latency alu, returns tagged results in order.
// Latency: accept at edge N, issue at N+1, capture at N+1+ALU_LATENCY, response valid after that edge.
// Backpressure: cmd_ready_out drops when the command FIFO is full; issue stalls on zero response credit.
// Ports: clock/reset (async, active-high); cmd_* valid/ready command input; alu_*_out registered
//        operands to the alu, alu_result_in back from it; rsp_* valid/ready response output;
//        inflight_out = issued-but-not-captured count, saturating at 7.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH       = ALU_WIDTH,
  parameter int OP_WIDTH    = ALU_OP_WIDTH,
  parameter int RES_WIDTH   = ALU_RES_WIDTH,
  parameter int TAG_WIDTH   = ALU_TAG_WIDTH,
  parameter int CMD_DEPTH   = 8,
  parameter int RSP_DEPTH   = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid_in,
  output logic                 cmd_ready_out,
  input  logic [WIDTH-1:0]     cmd_a_in,
  input  logic [WIDTH-1:0]     cmd_b_in,
  input  logic [OP_WIDTH-1:0]  cmd_op_in,
  input  logic [TAG_WIDTH-1:0] cmd_tag_in,
  output logic [WIDTH-1:0]     alu_a_out,
  output logic [WIDTH-1:0]     alu_b_out,
  output logic [OP_WIDTH-1:0]  alu_op_out,
  input  logic [RES_WIDTH-1:0] alu_result_in,
  output logic                 rsp_valid_out,
  input  logic                 rsp_ready_in,
  output logic [RES_WIDTH-1:0] rsp_result_out,
  output logic [TAG_WIDTH-1:0] rsp_tag_out,
  output logic [2:0]           inflight_out
);

  typedef struct packed {
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [OP_WIDTH-1:0]  op;
    logic [TAG_WIDTH-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [RES_WIDTH-1:0] result;
    logic [TAG_WIDTH-1:0] tag;
  } rsp_t;

  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;

  // Command side
  cmd_t              cmd_push_dat, cmd_head;
  logic              cmd_push, cmd_full, cmd_empty;
  logic [CMD_CW-1:0] cmd_count;

  // Response side
  rsp_t              rsp_push_dat, rsp_head;
  logic              rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [RSP_CW-1:0] rsp_count;

  // Issue / credit
  logic issue, credit_ok;
  int   inflight_cnt;

  // Alu operand registers
  logic [WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH-1:0]    alu_b_q, alu_b_d;
  logic [OP_WIDTH-1:0] alu_op_q, alu_op_d;

  // Valid/tag pipe mirroring the alu latency; the last stage lines up with alu_result_in
  logic [ALU_LATENCY-1:0] vld_q, vld_d;
  logic [TAG_WIDTH-1:0]   tag_q [ALU_LATENCY];
  logic [TAG_WIDTH-1:0]   tag_d [ALU_LATENCY];

  // ---------------------------------------------------------------- command FIFO
  // Ready comes from the registered count only: a pop in the same cycle does
  // not open a slot until the next edge.
  assign cmd_ready_out = (cmd_count != CMD_CW'(CMD_DEPTH));
  assign cmd_push      = cmd_valid_in && cmd_ready_out;
  assign cmd_push_dat  = '{a: cmd_a_in, b: cmd_b_in, op: cmd_op_in, tag: cmd_tag_in};

  alu_sync_fifo #(
    .T     (cmd_t),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (cmd_push),
    .push_dat_i (cmd_push_dat),
    .pop_i      (issue),
    .head_o     (cmd_head),
    .full_o     (cmd_full),
    .empty_o    (cmd_empty),
    .count_o    (cmd_count)
  );

  // ---------------------------------------------------------------- credit / issue
  // Every issued command owns a response slot from issue until it leaves the
  // response FIFO, so counting pipe entries plus stored responses bounds the
  // FIFO occupancy at capture time. Same-cycle response pops are not credited
  // back until the count register updates.
  always_comb begin
    inflight_cnt = 0;
    for (int i = 0; i < ALU_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + int'(vld_q[i]);
    end
    credit_ok = (int'(rsp_count) + inflight_cnt) < RSP_DEPTH;
    issue     = !cmd_empty && credit_ok;
  end

  assign inflight_out = (inflight_cnt > 7) ? 3'd7 : 3'(inflight_cnt);

  // Operands hold their last value when idle; the pipe shifts every cycle.
  always_comb begin
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    if (issue) begin
      alu_a_d  = cmd_head.a;
      alu_b_d  = cmd_head.b;
      alu_op_d = cmd_head.op;
    end
    vld_d[0] = issue;
    tag_d[0] = issue ? cmd_head.tag : '0;
    for (int i = 1; i < ALU_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      vld_q    <= '0;
      for (int i = 0; i < ALU_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      vld_q    <= vld_d;
      for (int i = 0; i < ALU_LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign alu_a_out  = alu_a_q;
  assign alu_b_out  = alu_b_q;
  assign alu_op_out = alu_op_q;

  // ---------------------------------------------------------------- capture / response
  assign rsp_push     = vld_q[ALU_LATENCY-1];
  assign rsp_push_dat = '{result: alu_result_in, tag: tag_q[ALU_LATENCY-1]};
  assign rsp_pop      = rsp_valid_out && rsp_ready_in;

  alu_sync_fifo #(
    .T     (rsp_t),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (rsp_push),
    .push_dat_i (rsp_push_dat),
    .pop_i      (rsp_pop),
    .head_o     (rsp_head),
    .full_o     (rsp_full),
    .empty_o    (rsp_empty),
    .count_o    (rsp_count)
  );

  assign rsp_valid_out  = !rsp_empty;
  assign rsp_result_out = rsp_head.result;
  assign rsp_tag_out    = rsp_head.tag;

  // The credit scheme must make a capture into a full response FIFO impossible;
  // likewise a command push must never land on a full command FIFO.
  a_rsp_no_overflow: assert property (@(posedge clock) disable iff (reset) !(rsp_push && rsp_full));
  a_cmd_no_overflow: assert property (@(posedge clock) disable iff (reset) !(cmd_push && cmd_full));

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int L = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [7:0]  cmd_a_in, cmd_b_in;
  logic [3:0]  cmd_op_in, cmd_tag_in;
  logic [7:0]  alu_a_out, alu_b_out;
  logic [3:0]  alu_op_out;
  logic [15:0] alu_result_in;
  logic        rsp_valid_out;
  logic        rsp_ready_in;
  logic [15:0] rsp_result_out;
  logic [3:0]  rsp_tag_out;
  logic [2:0]  inflight_out;

  always #5 clock = ~clock;

  alu_cmd_issuer #(
    .WIDTH(8), .OP_WIDTH(4), .RES_WIDTH(16), .TAG_WIDTH(4),
    .CMD_DEPTH(8), .RSP_DEPTH(4), .ALU_LATENCY(L)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_a_in(cmd_a_in), .cmd_b_in(cmd_b_in), .cmd_op_in(cmd_op_in), .cmd_tag_in(cmd_tag_in),
    .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_op_out(alu_op_out),
    .alu_result_in(alu_result_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_result_out(rsp_result_out), .rsp_tag_out(rsp_tag_out),
    .inflight_out(inflight_out)
  );

  // Alu model: with latency 1 the result follows the registered operands directly.
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [15:0] ax, bx;
    ax = {8'h00, a};
    bx = {8'h00, b};
    case (op)
      OP_ADD:   return ax + bx;
      OP_SUB:   return ax - bx;
      OP_AND:   return ax & bx;
      OP_OR:    return ax | bx;
      OP_XOR:   return ax ^ bx;
      OP_MUL:   return ax * bx;
      OP_SHL:   return ax << b[2:0];
      OP_SHR:   return ax >> b[2:0];
      OP_PASSA: return ax;
      default:  return 16'h0000;
    endcase
  endfunction

  assign alu_result_in = alu_ref(alu_a_out, alu_b_out, alu_op_out);

  int       n_cmp = 0;
  int       n_fail = 0;
  int       acc_cnt = 0;
  int       pop_cnt = 0;
  int       cyc = 0;
  bit       last_acc;
  alu_rsp_t exp_q[$];
  int       pop_cyc_q[$];
  logic [3:0] pop_tag_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic [3:0]  tag;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle, called at a falling edge: drive, decide accept/pop from the
  // settled outputs, score any response leaving, then advance to the next falling edge.
  task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] op, input logic [3:0] tag, input bit rdy);
    alu_rsp_t e;
    cmd_valid_in = v;
    cmd_a_in     = a;
    cmd_b_in     = b;
    cmd_op_in    = op;
    cmd_tag_in   = tag;
    rsp_ready_in = rdy;
    #1;
    last_acc = v && cmd_ready_out;
    if (last_acc) begin
      exp_q.push_back('{result: alu_ref(a, b, op), tag: tag});
      acc_cnt++;
    end
    if (rsp_valid_out && rdy) begin
      pop_cnt++;
      pop_cyc_q.push_back(cyc);
      pop_tag_q.push_back(rsp_tag_out);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got tag %0h result %0h, required no response", rsp_tag_out, rsp_result_out);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", rsp_result_out, e.result);
        check("sb_tag", rsp_tag_out, e.tag);
      end
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 8'h00, 8'h00, 4'h0, 4'h0, rdy);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      idle(1'b1);
      g++;
    end
    check(name, exp_q.size(), 0);
    repeat (5) idle(1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int g;
    logic [7:0] ra, rb;
    logic [3:0] rop;

    tbl[0]  = '{8'h05, 8'h03, OP_ADD,   4'd2,  16'h0008};
    tbl[1]  = '{8'h10, 8'h03, OP_SUB,   4'd3,  16'h000D};
    tbl[2]  = '{8'h03, 8'h05, OP_SUB,   4'd4,  16'hFFFE};
    tbl[3]  = '{8'hF0, 8'h3C, OP_AND,   4'd5,  16'h0030};
    tbl[4]  = '{8'hF0, 8'h0F, OP_OR,    4'd6,  16'h00FF};
    tbl[5]  = '{8'hAA, 8'hFF, OP_XOR,   4'd7,  16'h0055};
    tbl[6]  = '{8'hFF, 8'hFF, OP_MUL,   4'd8,  16'hFE01};
    tbl[7]  = '{8'h81, 8'h01, OP_SHL,   4'd9,  16'h0102};
    tbl[8]  = '{8'h81, 8'h07, OP_SHR,   4'hA,  16'h0001};
    tbl[9]  = '{8'h7E, 8'h99, OP_PASSA, 4'hB,  16'h007E};
    tbl[10] = '{8'hFF, 8'h01, OP_ADD,   4'hF,  16'h0100};

    reset = 1'b1;
    cmd_valid_in = 1'b0;
    cmd_a_in = '0; cmd_b_in = '0; cmd_op_in = '0; cmd_tag_in = '0;
    rsp_ready_in = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready_out, 1);
    check("rst_rsp_valid", rsp_valid_out, 0);
    check("rst_alu_a", alu_a_out, 0);
    check("rst_alu_op", alu_op_out, 0);
    check("rst_inflight", inflight_out, 0);
    check("rst_rsp_result", rsp_result_out, 0);
    @(negedge clock);

    // Single commands: latency counts the accept edge itself, so ALU_LATENCY+2.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag, 1'b1);
      check("tbl_accept", last_acc, 1);
      edges = 1;
      while (!rsp_valid_out && edges < 20) begin
        idle(1'b1);
        edges++;
      end
      check("tbl_latency", edges, L + 2);
      check("tbl_result", rsp_result_out, tbl[i].exp);
      check("tbl_tag", rsp_tag_out, tbl[i].tag);
      idle(1'b1);
      check("tbl_drained", rsp_valid_out, 0);
    end
    drain("tbl_drain");

    // Burst of 8 with the response side always ready.
    pop_cyc_q.delete();
    pop_tag_q.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(i * 3), 8'(i), OP_ADD, 4'(i), 1'b1);
      check("burst_accept", last_acc, 1);
    end
    g = 0;
    while (pop_cyc_q.size() < 8 && g < 40) begin
      idle(1'b1);
      g++;
    end
    check("burst_rsp_count", pop_cyc_q.size(), 8);
    if (pop_cyc_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("burst_tag_order", pop_tag_q[i], 4'(i));
        check("burst_back_to_back", pop_cyc_q[i], pop_cyc_q[0] + i);
      end
    end
    drain("burst_drain");

    // Response side stalled: 4 issued on credit, 8 buffered, rest refused.
    acc_cnt = 0;
    pop_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h10 + i), 8'(i), OP_ADD, 4'(i), 1'b0);
    end
    check("stall_accepted", acc_cnt, 12);
    check("stall_cmd_ready", cmd_ready_out, 0);
    check("stall_last_issued_a", alu_a_out, 8'h13);
    check("stall_inflight", inflight_out, 0);
    check("stall_rsp_valid", rsp_valid_out, 1);

    // Full command FIFO popped while still presenting: no accept that cycle.
    step(1'b1, 8'hEE, 8'h01, OP_ADD, 4'hC, 1'b1);
    check("full_no_accept_a", last_acc, 0);
    check("full_pop_cycle_ready", cmd_ready_out, 0);
    step(1'b1, 8'hEE, 8'h01, OP_ADD, 4'hC, 1'b1);
    check("full_no_accept_b", last_acc, 0);
    check("full_issued_next", alu_a_out, 8'h14);
    check("full_ready_next", cmd_ready_out, 1);
    step(1'b1, 8'hEE, 8'h01, OP_ADD, 4'hC, 1'b1);
    check("full_accept_c", last_acc, 1);
    drain("stall_drain");
    check("stall_total_rsp", pop_cnt, 13);

    // Reset with work in flight and queued.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h21 + i), 8'h02, OP_MUL, 4'(i), 1'b0);
    end
    check("rstmid_inflight_before", inflight_out, 1);
    check("rstmid_rsp_before", rsp_valid_out, 1);
    cmd_valid_in = 1'b0;
    reset = 1'b1;
    #1;
    check("rstmid_rsp_valid", rsp_valid_out, 0);
    check("rstmid_alu_a", alu_a_out, 0);
    check("rstmid_alu_b", alu_b_out, 0);
    check("rstmid_alu_op", alu_op_out, 0);
    check("rstmid_cmd_ready", cmd_ready_out, 1);
    check("rstmid_inflight", inflight_out, 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    pop_cnt = 0;
    repeat (10) idle(1'b1);
    check("rstmid_no_stale", pop_cnt, 0);

    // Random traffic against the scoreboard.
    acc_cnt = 0;
    g = 0;
    while (acc_cnt < 500 && g < 20000) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 4'($urandom_range(0, 9));
      step($urandom_range(0, 3) != 0, ra, rb, rop, 4'($urandom_range(0, 15)),
           $urandom_range(0, 2) != 0);
      g++;
    end
    check("rand_accepted", acc_cnt, 500);
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
